execute: RTL

//  EX stage of the 5-stage MIPS pipeline. Sits directly downstream of decode and consumes the id_ex_* bundle.

---
 rtl/execute.sv | 120 ++++++++++++
 1 files changed

// File: rtl/execute.sv
// EX stage of the 5-stage MIPS pipeline: ALU control, operand select, ALU, branch-target add,
// destination select, and the EX/MEM pipeline latch.
module execute #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        id_ex_wb,
    input  logic [2:0]        id_ex_mem,
    input  logic [3:0]        id_ex_execute,
    input  logic [DATA_W-1:0] id_ex_npc,
    input  logic [DATA_W-1:0] id_ex_readdat1,
    input  logic [DATA_W-1:0] id_ex_readdat2,
    input  logic [DATA_W-1:0] id_ex_sign_ext,
    input  logic [REG_AW-1:0] id_ex_instr_bits_2016,
    input  logic [REG_AW-1:0] id_ex_instr_bits_1511,
    output logic [1:0]        ex_mem_wb,
    output logic [2:0]        ex_mem_mem,
    output logic [DATA_W-1:0] ex_mem_add_result,
    output logic              ex_mem_zero,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] ex_mem_readdat2,
    output logic [REG_AW-1:0] ex_mem_write_reg
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_NOP = 4'b1111;

    function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = CTRL_NOP;
        case (aluop)
            2'b00: ctrl = CTRL_ADD;
            2'b01: ctrl = CTRL_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: ctrl = CTRL_ADD;
                    6'b100010: ctrl = CTRL_SUB;
                    6'b100100: ctrl = CTRL_AND;
                    6'b100101: ctrl = CTRL_OR;
                    6'b101010: ctrl = CTRL_SLT;
                    6'b100111: ctrl = CTRL_NOR;
                    default:   ctrl = CTRL_NOP;
                endcase
            end
            default: ctrl = CTRL_NOP;
        endcase
        return ctrl;
    endfunction

    // Unrecognised controls yield zero; ADD/SUB wrap with no overflow indication.
    function automatic logic [DATA_W-1:0] alu_eval(input logic [3:0] ctrl,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic [DATA_W-1:0]        res;
        a_s = a;
        b_s = b;
        res = '0;
        case (ctrl)
            CTRL_ADD: res = a + b;
            CTRL_SUB: res = a - b;
            CTRL_AND: res = a & b;
            CTRL_OR:  res = a | b;
            CTRL_NOR: res = ~(a | b);
            CTRL_SLT: res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            default:  res = '0;
        endcase
        return res;
    endfunction

    logic              regdst_p0;
    logic [1:0]        aluop_p0;
    logic              alusrc_p0;
    logic [3:0]        alu_ctrl_p0;
    logic [DATA_W-1:0] alu_b_p0;
    logic [DATA_W-1:0] alu_res_p0;
    logic              zero_p0;
    logic [DATA_W-1:0] add_res_p0;
    logic [REG_AW-1:0] write_reg_p0;

    assign {regdst_p0, aluop_p0, alusrc_p0} = id_ex_execute;

    assign alu_ctrl_p0  = alu_decode(aluop_p0, id_ex_sign_ext[5:0]);
    assign alu_b_p0     = alusrc_p0 ? id_ex_sign_ext : id_ex_readdat2;
    assign alu_res_p0   = alu_eval(alu_ctrl_p0, id_ex_readdat1, alu_b_p0);
    assign zero_p0      = (alu_res_p0 == '0);
    assign add_res_p0   = id_ex_npc + (id_ex_sign_ext << 2);
    assign write_reg_p0 = regdst_p0 ? id_ex_instr_bits_1511 : id_ex_instr_bits_2016;

    // ---- EX/MEM latch: flush zeroes only the control bundles ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_wb         <= '0;
            ex_mem_mem        <= '0;
            ex_mem_add_result <= '0;
            ex_mem_zero       <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_readdat2   <= '0;
            ex_mem_write_reg  <= '0;
        end else begin
            ex_mem_wb         <= flush ? 2'b00  : id_ex_wb;
            ex_mem_mem        <= flush ? 3'b000 : id_ex_mem;
            ex_mem_add_result <= add_res_p0;
            ex_mem_zero       <= zero_p0;
            ex_mem_alu_result <= alu_res_p0;
            ex_mem_readdat2   <= id_ex_readdat2;
            ex_mem_write_reg  <= write_reg_p0;
        end
    end

endmodule
